// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one PC-1 load, per-round C/D rotations, PC-2 subkey out.
// Latency: first subkey valid the cycle after start; one subkey per cycle when sk_ready stays high.
// Backpressure: sk_valid/sk_ready handshake; sk, sk_round and C/D hold while stalled.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, key        - begin a schedule from a 64-bit DES key (key[63] = DES bit 1), sampled in IDLE
//   dec               - decrypt order select, sampled with start (only with DES_KEY_DEC_EN)
//   busy              - schedule in progress
//   sk_valid/sk_ready - subkey handshake
//   sk, sk_round      - 48-bit subkey (sk[47] = DES bit 1) and its round index 0..15
//   done              - one-cycle pulse the cycle after the last subkey is accepted
//
// Optional feature macro: DES_KEY_DEC_EN adds the dec port and reverse (K16..K1) order.

module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key,
`ifdef DES_KEY_DEC_EN
    input  logic        dec,
`endif
    output logic        busy,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] sk,
    output logic [3:0]  sk_round,
    output logic        done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Bit i set means round i+1 rotates by two; rounds 1, 2, 9 and 16 rotate by one.
    localparam logic [15:0] SHIFT2 = 16'h7EFC;

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        done_q, done_d;
    logic        last_round;
`ifdef DES_KEY_DEC_EN
    logic        dec_q, dec_d;
`endif

    // PC-1 left half: DES key bit p lives at key[64-p].
    function automatic logic [27:0] pc1_c(input logic [63:0] k);
        return {k[7],  k[15], k[23], k[31], k[39], k[47], k[55], k[63],
                k[6],  k[14], k[22], k[30], k[38], k[46], k[54], k[62],
                k[5],  k[13], k[21], k[29], k[37], k[45], k[53], k[61],
                k[4],  k[12], k[20], k[28]};
    endfunction

    // PC-1 right half.
    function automatic logic [27:0] pc1_d(input logic [63:0] k);
        return {k[1],  k[9],  k[17], k[25], k[33], k[41], k[49], k[57],
                k[2],  k[10], k[18], k[26], k[34], k[42], k[50], k[58],
                k[3],  k[11], k[19], k[27], k[35], k[43], k[51], k[59],
                k[36], k[44], k[52], k[60]};
    endfunction

    // PC-2 over the 56-bit {C,D}: DES bit q of CD lives at cd[56-q].
    function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        cd = {c, d};
        return {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51], cd[53], cd[28],
                cd[41], cd[50], cd[35], cd[46], cd[33], cd[37], cd[44], cd[52],
                cd[30], cd[48], cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
                cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],  cd[26], cd[16],
                cd[5],  cd[11], cd[23], cd[8],  cd[12], cd[7],  cd[17], cd[0],
                cd[22], cd[3],  cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};
    endfunction

    // Left rotate of a 28-bit half by one or two positions (MSB is DES bit 1).
    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

`ifdef DES_KEY_DEC_EN
    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction
`endif

    // The final subkey is K16 in encrypt order and K1 in decrypt order.
`ifdef DES_KEY_DEC_EN
    assign last_round = dec_q ? (round_q == 4'd0) : (round_q == 4'd15);
`else
    assign last_round = (round_q == 4'd15);
`endif

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
`ifdef DES_KEY_DEC_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            done_q  <= done_d;
`ifdef DES_KEY_DEC_EN
            dec_q   <= dec_d;
`endif
        end
    end

    // Next-state logic, including C/D advance on each accepted beat.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        done_d  = 1'b0;
`ifdef DES_KEY_DEC_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
`ifdef DES_KEY_DEC_EN
                    dec_d = dec;
                    if (dec) begin
                        // C16/D16 equal C0/D0 since the total rotation is 28.
                        c_d     = pc1_c(key);
                        d_d     = pc1_d(key);
                        round_d = 4'd15;
                    end else begin
                        c_d     = rotl(pc1_c(key), 1'b0);
                        d_d     = rotl(pc1_d(key), 1'b0);
                        round_d = 4'd0;
                    end
`else
                    // Pre-rotate by round 1's shift so K1 is ready next cycle.
                    c_d     = rotl(pc1_c(key), 1'b0);
                    d_d     = rotl(pc1_d(key), 1'b0);
                    round_d = 4'd0;
`endif
                end
            end
            S_RUN: begin
                if (sk_ready) begin
                    if (last_round) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
`ifdef DES_KEY_DEC_EN
                    if (dec_q) begin
                        // Undo the rotation that produced the current round.
                        c_d     = rotr(c_q, SHIFT2[round_q]);
                        d_d     = rotr(d_q, SHIFT2[round_q]);
                        round_d = round_q - 4'd1;
                    end else begin
                        c_d     = rotl(c_q, SHIFT2[round_q + 4'd1]);
                        d_d     = rotl(d_q, SHIFT2[round_q + 4'd1]);
                        round_d = round_q + 4'd1;
                    end
`else
                    // Apply the next round's shift; the wrap after K16 is harmless.
                    c_d     = rotl(c_q, SHIFT2[round_q + 4'd1]);
                    d_d     = rotl(d_q, SHIFT2[round_q + 4'd1]);
                    round_d = round_q + 4'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend on registers only; sk_ready never reaches sk or sk_valid.
    always_comb begin
        busy     = (state_q == S_RUN);
        sk_valid = (state_q == S_RUN);
        sk_round = round_q;
        done     = done_q;
        sk       = pc2(c_q, d_q);
    end

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dec = 1'b0;
    logic        sk_ready = 1'b0;
    logic [63:0] key = '0;
    logic        busy, sk_valid, done;
    logic [47:0] sk;
    logic [3:0]  sk_round;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key      (key),
`ifdef DES_KEY_DEC_EN
        .dec      (dec),
`endif
        .busy     (busy),
        .sk_valid (sk_valid),
        .sk_ready (sk_ready),
        .sk       (sk),
        .sk_round (sk_round),
        .done     (done)
    );

    // Reference tables straight from the DES standard (1-based bit positions).
    int PC1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                     10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    int PC2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                     23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                     41,52,31,37,47,55,30,40,51,45,33,48,
                     44,49,39,56,34,53,46,42,50,36,29,32};
    int SH  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] ref_ks [16];
    logic [47:0] first_sk, last_sk;
    int          done_cnt;

    // Subkey Ki (r = i-1): C0/D0 rotated left by the cumulative shift, then PC-2.
    function automatic logic [47:0] model_sk(input logic [63:0] k, input int r);
        int kb [65];
        int c0 [28];
        int d0 [28];
        int cd [57];
        int tot;
        logic [47:0] o;
        tot = 0;
        for (int i = 0; i <= r; i++) tot += SH[i];
        for (int p = 1; p <= 64; p++) kb[p] = int'((k >> (64 - p)) & 64'd1);
        for (int j = 0; j < 28; j++) begin
            c0[j] = kb[PC1[j]];
            d0[j] = kb[PC1[28 + j]];
        end
        cd[0] = 0;
        for (int j = 0; j < 28; j++) begin
            cd[1 + j]  = c0[(j + tot) % 28];
            cd[29 + j] = d0[(j + tot) % 28];
        end
        o = '0;
        for (int i = 0; i < 48; i++) o = (o << 1) | 48'(cd[PC2[i]]);
        return o;
    endfunction

    task automatic build_ref(input logic [63:0] k);
        for (int r = 0; r < 16; r++) ref_ks[r] = model_sk(k, r);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Issues start, consumes all 16 subkeys, returns at the done cycle.
    task automatic run_sched(input logic [63:0] k, input logic d, input bit stall, input bit poke);
        int acc, cyc, idx;
        bit rdy;
        build_ref(k);
        key   = k;
        dec   = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = {$urandom, $urandom};
        acc = 0;
        cyc = 0;
        while (acc < 16 && cyc < 300) begin
            idx = d ? 15 - acc : acc;
            chk("valid", 64'(sk_valid), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("sk", 64'(sk), 64'(ref_ks[idx]));
            chk("sk_round", 64'(sk_round), 64'(idx));
            chk("done_early", 64'(done), 64'd0);
            if (acc == 0) first_sk = sk;
            if (acc == 15) last_sk = sk;
            // A start with a different key mid-run must be ignored.
            start = (poke && acc == 3);
            if (poke && acc == 3) key = ~k;
            rdy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            sk_ready = rdy;
            if (rdy) acc++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("all_accepted", 64'(acc), 64'd16);
        chk("done_pulse", 64'(done), 64'd1);
        chk("valid_drop", 64'(sk_valid), 64'd0);
        chk("busy_drop", 64'(busy), 64'd0);
        if (!stall) chk("latency", 64'(cyc), 64'd16);
    endtask

    localparam logic [63:0] KAT = 64'h133457799BBCDFF1;

    initial begin
        int seen_done;
        sk_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(sk_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sk", 64'(sk), 64'd0);
        chk("rst_round", 64'(sk_round), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known answer, encrypt order, no stalls.
        run_sched(KAT, 1'b0, 1'b0, 1'b0);
        chk("kat_first", 64'(first_sk), 64'h1B02EFFC7072);
        chk("kat_last", 64'(last_sk), 64'hCB3D8B0E17F5);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);

        // Parity bits ignored.
        run_sched(64'h0101010101010101, 1'b0, 1'b0, 1'b0);
        chk("parity_first", 64'(first_sk), 64'd0);
        chk("parity_last", 64'(last_sk), 64'd0);
        @(negedge clk);

        // Back-pressure with random ready.
        run_sched(KAT, 1'b0, 1'b1, 1'b0);
        chk("bp_first", 64'(first_sk), 64'h1B02EFFC7072);
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            run_sched({$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end

        // start while busy is ignored.
        run_sched(KAT, 1'b0, 1'b1, 1'b1);
        @(negedge clk);

        // Back-to-back: second start in the done cycle.
        run_sched({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        run_sched({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset at round 7.
        key = KAT;
        dec = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sk_ready = 1'b1;
        repeat (7) @(negedge clk);
        chk("pre_rst_round", 64'(sk_round), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(sk_valid), 64'd0);
        chk("mid_rst_sk", 64'(sk), 64'd0);
        chk("mid_rst_round", 64'(sk_round), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int n = 0; n < 20; n++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        chk("no_done_after_rst", 64'(seen_done), 64'd0);
        run_sched(KAT, 1'b0, 1'b0, 1'b0);
        chk("post_rst_first", 64'(first_sk), 64'h1B02EFFC7072);
        @(negedge clk);

`ifdef DES_KEY_DEC_EN
        run_sched(KAT, 1'b1, 1'b0, 1'b0);
        chk("dec_first", 64'(first_sk), 64'hCB3D8B0E17F5);
        chk("dec_last", 64'(last_sk), 64'h1B02EFFC7072);
        @(negedge clk);
        run_sched({$urandom, $urandom}, 1'b1, 1'b1, 1'b0);
        run_sched({$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
